digit_capture_ctrl: RTL and testbench
=====================================

DIGIT_CAPTURE_CTRL -- requirements
Module: digit_capture_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, giving settle cycles per digit before sampling; legal range 1 to 2^20-1.
REQ-002 Port clk_in, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request one four-digit capture frame; sampled only in IDLE.
REQ-005 Port seg_in, input, 8 bits: active-low segment pattern currently driven on the display bus.
REQ-006 Port an, output, 4 bits: active-low one-hot digit select for the digit being sampled; 4'b1111 when not scanning.
REQ-007 Port busy, output, 1 bit: high in every state except IDLE.
REQ-008 Port frame_valid, output, 1 bit: captured frame available on bcd/err.
REQ-009 Port frame_ready, input, 1 bit: consumer accepts the frame.
REQ-010 Port bcd, output, 16 bits: digit0 in [3:0] through digit3 in [15:12].
REQ-011 Port err, output, 1 bit: at least one digit in the frame had an invalid pattern.
REQ-012 Port err_mask, output, 4 bits: per-digit invalid flags, bit i for digit i (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE, HOLD.
REQ-014 IDLE with start=1 SHALL go to SETTLE with digit index 0 and settle counter 0; start=0 stays in IDLE.
REQ-015 In SETTLE and SAMPLE, an SHALL be ~(4'b0001 << index): index 0 gives 4'b1110, index 3 gives 4'b0111.
REQ-016 SETTLE SHALL increment the counter each cycle and go to SAMPLE on the cycle the counter equals SCAN_DIV-1; with SCAN_DIV=1 it therefore lasts exactly one cycle.
REQ-017 SAMPLE SHALL last one cycle and register the decode of seg_in into shadow nibble[index] using this mapping: C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 90->9.
REQ-018 Any other seg_in value sampled in SAMPLE SHALL store 4'hF in the nibble and set shadow error bit[index].
REQ-019 From SAMPLE with index<3, the FSM SHALL increment the index, clear the counter, and return to SETTLE.
REQ-020 From SAMPLE with index==3, the FSM SHALL go to HOLD and load bcd, err (OR of the shadow error bits) and err_mask from the shadow registers in that same edge.
REQ-021 Shadow error bits SHALL be cleared on leaving IDLE.
REQ-022 In HOLD, frame_valid SHALL be 1 and an SHALL be 4'b1111; bcd, err and err_mask SHALL be stable until the next frame loads.
REQ-023 In HOLD with frame_ready=1, the FSM SHALL go to IDLE, and frame_valid SHALL be 0 from the next cycle.
REQ-024 bcd, err and err_mask SHALL retain the last frame while in IDLE and during the next scan.
REQ-025 start SHALL be ignored outside IDLE, including in the cycle HOLD exits; a new frame requires start high while in IDLE.
REQ-026 Latency: with start sampled in IDLE at edge t, frame_valid SHALL first be high after edge t+4*(SCAN_DIV+1).
REQ-027 The settle counter SHALL be at least 20 bits wide and SHALL never wrap within a frame.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, an=4'b1111, busy=0, frame_valid=0, bcd=16'h0000, err=0, err_mask=4'b0000, index=0, counter=0, shadow registers 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no partial update of bcd; operation SHALL resume only on a new start after rst_n returns high.

Configuration
REQ-030 When macro DIGIT_CAPTURE_ERR_MASK_EN is defined, err_mask SHALL carry the per-digit shadow error bits as loaded in REQ-020.
REQ-031 When DIGIT_CAPTURE_ERR_MASK_EN is undefined, err_mask SHALL be constant 4'b0000 and no per-digit mask register SHALL be synthesized; err behaviour is unchanged.

Verification (SCAN_DIV=4)
REQ-032 Start pulse with seg_in=C0,F9,A4,B0 presented while an selects digits 0..3 -> bcd=16'h3210, err=0, and frame_valid rises exactly 20 cycles after the start edge.
REQ-033 Same as REQ-032 but digit2 pattern is 8'hFF -> bcd=16'h3F10, err=1; err_mask=4'b0100 with the macro, 4'b0000 without it.
REQ-034 frame_ready held low for 10 cycles in HOLD with start pulsed -> frame_valid=1, bcd and an=4'b1111 stable throughout; frame_ready=1 -> IDLE, frame_valid=0 on the next cycle.
REQ-035 rst_n pulsed low during SETTLE of digit 1 -> an=4'b1111, busy=0, frame_valid=0 asynchronously and bcd=0; a later start performs a full 4-digit frame.
REQ-036 SCAN_DIV=1, start held high continuously -> frame_valid after 8 cycles; after frame_ready, one IDLE cycle precedes the next frame; an sequence is 1110, 1101, 1011, 0111 with two cycles per digit.

Source files
------------

// File: rtl/digit_capture_ctrl.sv
// Scans four multiplexed 7-segment digits, decodes each to BCD and presents the frame.
// Define DIGIT_CAPTURE_ERR_MASK_EN to register per-digit invalid flags on err_mask.
module digit_capture_ctrl #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  seg_in,
    output logic [3:0]  an,
    output logic        busy,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [15:0] bcd,
    output logic        err,
    output logic [3:0]  err_mask
);

    localparam int unsigned CntW = 20;
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StHold} state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     sh_bcd_q, sh_bcd_d;
    logic [3:0]      sh_err_q, sh_err_d;
    logic [15:0]     bcd_q, bcd_d;
    logic            err_q, err_d;
    logic [3:0]      dec_nib;
    logic            dec_bad;
    logic            last_sample;

    assign last_sample = (state_q == StSample) && (idx_q == 2'd3);

    // Active-low segment pattern to BCD; anything unrecognised flags the digit.
    always_comb begin
        dec_bad = 1'b0;
        case (seg_in)
            8'hC0:   dec_nib = 4'd0;
            8'hF9:   dec_nib = 4'd1;
            8'hA4:   dec_nib = 4'd2;
            8'hB0:   dec_nib = 4'd3;
            8'h99:   dec_nib = 4'd4;
            8'h92:   dec_nib = 4'd5;
            8'h82:   dec_nib = 4'd6;
            8'hF8:   dec_nib = 4'd7;
            8'h80:   dec_nib = 4'd8;
            8'h90:   dec_nib = 4'd9;
            default: begin
                dec_nib = 4'hF;
                dec_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (cnt_q == CntLast) state_d = StSample;
            StSample: state_d = (idx_q == 2'd3) ? StHold : StSettle;
            StHold:   if (frame_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        an          = 4'b1111;
        busy        = (state_q != StIdle);
        frame_valid = (state_q == StHold);
        if (state_q == StSettle || state_q == StSample) begin
            an = ~(4'b0001 << idx_q);
        end
    end

    always_comb begin
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sh_bcd_d = sh_bcd_q;
        sh_err_d = sh_err_q;
        bcd_d    = bcd_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d    = 2'd0;
                    cnt_d    = '0;
                    sh_err_d = 4'b0000;
                end
            end
            StSettle: cnt_d = cnt_q + CntW'(1);
            StSample: begin
                sh_bcd_d[{idx_q, 2'b00} +: 4] = dec_nib;
                sh_err_d[idx_q]               = dec_bad;
                if (idx_q != 2'd3) begin
                    idx_d = idx_q + 2'd1;
                    cnt_d = '0;
                end else begin
                    // Final digit is folded in on the same edge the frame is published.
                    bcd_d = sh_bcd_d;
                    err_d = |sh_err_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            sh_bcd_q <= 16'h0000;
            sh_err_q <= 4'b0000;
            bcd_q    <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sh_bcd_q <= sh_bcd_d;
            sh_err_q <= sh_err_d;
            bcd_q    <= bcd_d;
            err_q    <= err_d;
        end
    end

    assign bcd = bcd_q;
    assign err = err_q;

`ifdef DIGIT_CAPTURE_ERR_MASK_EN
    logic [3:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (last_sample) mask_d = sh_err_d;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 4'b0000;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign err_mask = mask_q;
`else
    logic unused_last_sample;
    assign unused_last_sample = last_sample;
    assign err_mask           = 4'b0000;
`endif

endmodule

// File: tb/tb_digit_capture_ctrl.sv
// Bench for digit_capture_ctrl: fixed vector table, random frames against a lookup model,
// and directed hold / reset / back-to-back sequences.
module tb_digit_capture_ctrl;

    localparam int unsigned ScanDiv = 4;
    localparam int unsigned FrameLat = 4 * (ScanDiv + 1);

    logic        clk_in, rst_n;
    logic        start, frame_ready;
    logic [7:0]  seg_in;
    logic [3:0]  an, err_mask;
    logic        busy, frame_valid, err;
    logic [15:0] bcd;

    logic        start_f, frame_ready_f;
    logic [7:0]  seg_f;
    logic [3:0]  an_f, err_mask_f;
    logic        busy_f, frame_valid_f, err_f;
    logic [15:0] bcd_f;

    logic [7:0] pat [4];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    digit_capture_ctrl #(.SCAN_DIV(ScanDiv)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start       (start),
        .seg_in      (seg_in),
        .an          (an),
        .busy        (busy),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .bcd         (bcd),
        .err         (err),
        .err_mask    (err_mask)
    );

    digit_capture_ctrl #(.SCAN_DIV(1)) dut_fast (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start       (start_f),
        .seg_in      (seg_f),
        .an          (an_f),
        .busy        (busy_f),
        .frame_valid (frame_valid_f),
        .frame_ready (frame_ready_f),
        .bcd         (bcd_f),
        .err         (err_f),
        .err_mask    (err_mask_f)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // The display bus drives whichever digit the anode select points at.
    always_comb begin
        case (an)
            4'b1110: seg_in = pat[0];
            4'b1101: seg_in = pat[1];
            4'b1011: seg_in = pat[2];
            4'b0111: seg_in = pat[3];
            default: seg_in = 8'hFF;
        endcase
    end

    always_comb begin
        case (an_f)
            4'b1110: seg_f = 8'hC0;
            4'b1101: seg_f = 8'hF9;
            4'b1011: seg_f = 8'hA4;
            4'b0111: seg_f = 8'hB0;
            default: seg_f = 8'hFF;
        endcase
    end

    typedef struct {
        logic [31:0] segs;
        logic [15:0] bcd;
        logic        err;
        logic [3:0]  mask;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_mask(input logic [3:0] m);
`ifdef DIGIT_CAPTURE_ERR_MASK_EN
        return m;
`else
        return 4'b0000 & m;
`endif
    endfunction

    function automatic logic [4:0] ref_digit(input logic [7:0] s);
        logic [7:0] codes [10];
        codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        for (int i = 0; i < 10; i++) begin
            if (s == codes[i]) return {1'b0, 4'(i)};
        end
        return {1'b1, 4'hF};
    endfunction

    function automatic vec_t ref_frame(input logic [31:0] segs);
        vec_t v;
        logic [4:0] d;
        v.segs = segs;
        v.bcd  = '0;
        v.mask = '0;
        for (int i = 0; i < 4; i++) begin
            d = ref_digit(segs[8*i +: 8]);
            v.bcd[4*i +: 4] = d[3:0];
            v.mask[i]       = d[4];
        end
        v.err = |v.mask;
        return v;
    endfunction

    // Called just after a clock edge with the DUT idle; leaves it in HOLD.
    task automatic run_frame(input logic [31:0] segs, output int lat, output logic an_ok);
        for (int i = 0; i < 4; i++) pat[i] = segs[8*i +: 8];
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        lat   = 0;
        an_ok = 1'b1;
        while (!frame_valid && lat < 200) begin
            if (lat < int'(FrameLat) && an !== ~(4'b0001 << (lat / (ScanDiv + 1))))
                an_ok = 1'b0;
            @(posedge clk_in);
            #1 lat++;
        end
    endtask

    task automatic accept(input string name);
        frame_ready = 1'b1;
        @(posedge clk_in);
        #1 frame_ready = 1'b0;
        check({name, "_fv_drop"}, {31'd0, frame_valid}, 32'd0);
    endtask

    task automatic apply(input string name, input vec_t v);
        int   lat;
        logic an_ok;
        run_frame(v.segs, lat, an_ok);
        check({name, "_latency"}, lat, FrameLat);
        check({name, "_an_seq"}, {31'd0, an_ok}, 32'd1);
        check({name, "_bcd"}, {16'd0, bcd}, {16'd0, v.bcd});
        check({name, "_err"}, {31'd0, err}, {31'd0, v.err});
        check({name, "_mask"}, {28'd0, err_mask}, {28'd0, exp_mask(v.mask)});
    endtask

    initial begin
        vec_t        vecs [6];
        vec_t        rv;
        logic [31:0] segs;
        logic [7:0]  codes [10];
        logic [15:0] bcd0;
        logic        stable;
        int          n;
        logic        an_ok;

        vecs[0] = '{32'hB0A4F9C0, 16'h3210, 1'b0, 4'b0000};
        vecs[1] = '{32'hB0FFF9C0, 16'h3F10, 1'b1, 4'b0100};
        vecs[2] = '{32'hF8829299, 16'h7654, 1'b0, 4'b0000};
        vecs[3] = '{32'hC0C09080, 16'h0098, 1'b0, 4'b0000};
        vecs[4] = '{32'h7F90FF00, 16'hF9FF, 1'b1, 4'b1011};
        vecs[5] = '{32'h80A4F9C1, 16'h821F, 1'b1, 4'b0001};
        codes   = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

        for (int i = 0; i < 4; i++) pat[i] = 8'hFF;
        rst_n = 1'b0; start = 1'b0; frame_ready = 1'b0;
        start_f = 1'b0; frame_ready_f = 1'b0;
        #12;
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        check("rst_bcd_err_mask", {11'd0, bcd, err, err_mask}, 32'd0);
        @(negedge clk_in) rst_n = 1'b1;
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 6; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
            accept($sformatf("vec%0d", i));
        end

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 4; i++) begin
                segs[8*i +: 8] = ($urandom_range(3) != 0) ? codes[$urandom_range(9)]
                                                         : 8'($urandom);
            end
            rv = ref_frame(segs);
            apply($sformatf("rnd%0d", k), rv);
            accept($sformatf("rnd%0d", k));
        end

        // Hold for ten cycles while start is pulsed; outputs must not move.
        apply("hold", vecs[2]);
        bcd0   = bcd;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            @(posedge clk_in);
            #1;
            if (!frame_valid || !busy || an !== 4'b1111 || bcd !== bcd0) stable = 1'b0;
        end
        check("hold_stable", {31'd0, stable}, 32'd1);
        // start high on the HOLD exit edge must not launch a frame.
        start       = 1'b1;
        frame_ready = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        frame_ready = 1'b0;
        check("hold_exit_fv", {31'd0, frame_valid}, 32'd0);
        @(posedge clk_in);
        #1 check("start_ignored_exit", {31'd0, busy}, 32'd0);

        // Reset during the settle phase of digit 1.
        for (int i = 0; i < 4; i++) pat[i] = 8'hC0;
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        n = 0;
        while (an !== 4'b1101 && n < 50) begin
            @(posedge clk_in);
            #1 n++;
        end
        check("reach_digit1", {31'd0, n < 50}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_an", {28'd0, an}, 32'hF);
        check("mid_rst_busy_fv", {30'd0, busy, frame_valid}, 32'd0);
        check("mid_rst_bcd", {11'd0, bcd, err, err_mask}, 32'd0);
        @(negedge clk_in) rst_n = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 check("no_resume", {31'd0, busy}, 32'd0);
        apply("post_rst", vecs[0]);
        accept("post_rst");

        // SCAN_DIV=1 instance with start held high.
        start_f = 1'b1;
        @(posedge clk_in);
        #1 n = 0;
        an_ok = 1'b1;
        while (!frame_valid_f && n < 100) begin
            if (n < 8 && an_f !== ~(4'b0001 << (n / 2))) an_ok = 1'b0;
            @(posedge clk_in);
            #1 n++;
        end
        check("fast_latency", n, 32'd8);
        check("fast_an_seq", {31'd0, an_ok}, 32'd1);
        check("fast_bcd", {16'd0, bcd_f}, 32'h3210);
        frame_ready_f = 1'b1;
        @(posedge clk_in);
        #1 frame_ready_f = 1'b0;
        check("fast_idle_gap", {30'd0, busy_f, frame_valid_f}, 32'd0);
        @(posedge clk_in);
        #1 check("fast_restart", {27'd0, busy_f, an_f}, {27'd0, 1'b1, 4'b1110});
        start_f = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
